// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and helpers shared by the FIFO files.
//   cnt_width(depth) : width of a fill-level counter that can hold 0..depth
//   FIFO_STD         : registered read mode selector
//   FIFO_FWFT        : first-word-fall-through mode selector
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // One bit more than the address width so that count can reach DEPTH.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH flop array with one write port and one read port.
//   clk    in  clock; writes happen on the rising edge
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out combinational read data at raddr
// Contents are never reset.
module fifo_mem #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Storage write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with fill level, almost-full/almost-empty
// thresholds, optional first-word-fall-through read, synchronous flush and
// sticky overflow/underflow flags.
//   clk           in  clock, rising edge
//   rst_n         in  synchronous active-low reset
//   clr           in  synchronous flush, overrides wen/ren
//   wen, wdata    in  write request and data
//   ren           in  read request (standard) / pop (FWFT)
//   rdata         out read data (registered in standard mode, head word in FWFT)
//   empty, full   out registered fill flags
//   almost_empty  out count <= AEMPTY_THRESH
//   almost_full   out count >= AFULL_THRESH
//   count         out fill level 0..DEPTH
//   overflow      out sticky, a write was rejected
//   underflow     out sticky, a read was rejected
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH         = 36,
   parameter int DEPTH         = 256,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 1,
   parameter int FWFT          = FIFO_STD,
   localparam int AW           = $clog2(DEPTH),
   localparam int CW           = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wen,
   input  logic [WIDTH-1:0] wdata,
   input  logic             ren,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   logic [AW-1:0]    wptr_r;
   logic [AW-1:0]    rptr_r;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_nxt_s;
   logic             empty_r;
   logic             full_r;
   logic             aempty_r;
   logic             afull_r;
   logic             overflow_r;
   logic             underflow_r;
   logic             wr_acc_s;
   logic             rd_acc_s;
   logic             mem_we_s;
   logic [WIDTH-1:0] mem_rdata_s;

   // Acceptance uses the registered flags only, so no input reaches an output.
   assign wr_acc_s = wen & ~full_r;
   assign rd_acc_s = ren & ~empty_r;
   // Flush and reset suppress the write so the ignored request leaves no trace.
   assign mem_we_s = wr_acc_s & rst_n & ~clr;

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .waddr (wptr_r),
      .wdata (wdata),
      .raddr (rptr_r),
      .rdata (mem_rdata_s)
   );

   // Next fill level from the accepted write/read pair.
   always_comb begin
      count_nxt_s = count_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, count, flags and sticky errors.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wptr_r      <= {AW{1'b0}};
         rptr_r      <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         empty_r     <= 1'b1;
         full_r      <= 1'b0;
         aempty_r    <= 1'b1;
         afull_r     <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wptr_r <= wptr_r + AW'(1);
         end
         if (rd_acc_s) begin
            rptr_r <= rptr_r + AW'(1);
         end
         count_r     <= count_nxt_s;
         // Flags follow the next count so they match count every cycle.
         empty_r     <= (count_nxt_s == {CW{1'b0}});
         full_r      <= (count_nxt_s == CW'(DEPTH));
         aempty_r    <= (count_nxt_s <= CW'(AEMPTY_THRESH));
         afull_r     <= (count_nxt_s >= CW'(AFULL_THRESH));
         overflow_r  <= overflow_r  | (wen & full_r);
         underflow_r <= underflow_r | (ren & empty_r);
      end
   end

   generate
      if (FWFT == FIFO_FWFT) begin : g_fwft
         // Head word is visible straight from storage; meaningless while empty.
         assign rdata = mem_rdata_s;
      end else begin : g_std
         logic [WIDTH-1:0] rdata_r;

         // Read data register, loaded only by an accepted read.
         always_ff @(posedge clk) begin
            if (!rst_n || clr) begin
               rdata_r <= {WIDTH{1'b0}};
            end else if (rd_acc_s) begin
               rdata_r <= mem_rdata_s;
            end
         end

         assign rdata = rdata_r;
      end
   endgenerate

   assign empty        = empty_r;
   assign full         = full_r;
   assign almost_empty = aempty_r;
   assign almost_full  = afull_r;
   assign count        = count_r;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

endmodule : sync_fifo

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised successor to the dual-clock FIFO. It adds a fill-level output, programmable almost-full and almost-empty thresholds, a first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow error flags. It is used wherever producer and consumer share a clock, in front of packet and stream engines that need back-pressure ahead of hard full.

## Interface
- WIDTH, 36: data word width in bits, ≥1.
- DEPTH, 256: number of entries; power of two, ≥2. AW = $clog2(DEPTH).
- AFULL_THRESH, DEPTH-2: almost_full asserts when count ≥ AFULL_THRESH; range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty asserts when count ≤ AEMPTY_THRESH; range 0..DEPTH-1.
- FWFT, 0: 0 selects standard registered read; 1 selects first-word-fall-through.
- clk  in  1  the single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clr  in  1  synchronous flush; has priority over wen and ren.
- wen  in  1  write request.
- wdata  in  WIDTH  write data.
- ren  in  1  read request (standard mode) or pop (FWFT mode).
- rdata  out  WIDTH  read data.
- empty  out  1  no readable word.
- full  out  1  DEPTH words stored.
- almost_empty  out  1  count ≤ AEMPTY_THRESH.
- almost_full  out  1  count ≥ AFULL_THRESH.
- count  out  AW+1  current fill level, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- Accept rules use the registered flags at the clock edge:
  - write accepted = wen & !full;
  - read accepted = ren & !empty.
- Simultaneous wen and ren:
  - both accepted: count unchanged, both pointers advance;
  - when full: the read is accepted, the write is rejected and overflow sets;
  - when empty: the write is accepted, the read is rejected and underflow sets.
- Pointers are AW bits and wrap from DEPTH-1 to 0 naturally. count is tracked explicitly; it is not derived from the pointers.
- Storage is a flop array with one write port and one combinational read port at rptr.
- Standard mode (FWFT=0):
  - an accepted read loads mem[rptr] into the rdata register;
  - rdata holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT=1):
  - rdata is mem[rptr] combinationally and is valid whenever !empty;
  - an accepted ren pops the head word;
  - rdata is don't-care while empty.
- Flags are registered and computed from next-state count, so they always agree with count in the same cycle:
  - full = (count == DEPTH);
  - empty = (count == 0);
  - almost_full = (count ≥ AFULL_THRESH);
  - almost_empty = (count ≤ AEMPTY_THRESH).
- clr, on the next edge:
  - pointers and count go to 0;
  - flags take their reset values;
  - overflow and underflow clear;
  - rdata goes to 0;
  - wen and ren in that cycle are ignored and set no error flag.
- Reset (rst_n low at an edge) applies the same state as clr, regardless of any operation in progress. Memory contents are not reset.

## Timing
- Reset values:
  - rdata = 0, count = 0;
  - empty = 1, almost_empty = 1;
  - full = 0, almost_full = 0, overflow = 0, underflow = 0.
- Write-to-flag latency: a write accepted at edge N updates count and flags after edge N.
- Standard-mode read latency: a read accepted at edge N presents data on rdata after edge N, i.e. one cycle.
- FWFT write-to-visible latency: the first word written into an empty FIFO at edge N appears on rdata, with empty low, after edge N.
- Overflow and underflow assert in the cycle after the offending request and stay high until clr or reset.
- No combinational path from wen or ren to any output. In FWFT mode rdata depends combinationally only on state.

## Structure
- The shared package fifo_pkg holds:
  - the count-width helper function (AW+1);
  - the FWFT mode constants FIFO_STD = 0 and FIFO_FWFT = 1.
- One sub-module, fifo_mem: a parametrised WIDTH×DEPTH flop array with a synchronous write port and an asynchronous read port.
- Pointer, count, flag and error logic stays in sync_fifo.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1.
- Reset, then idle: count=0, empty=1, almost_empty=1, full=0, rdata=0.
- Write 0x11, 0x22, 0x33, 0x44 on consecutive edges:
  - count steps 1, 2, 3, 4;
  - almost_empty drops at count=2, almost_full rises at count=3, full rises at count=4.
- Write 0x55 while full: the write is ignored, overflow=1 next cycle, count stays 4.
- FWFT=0: read four times. rdata = 0x11, 0x22, 0x33, 0x44, each one cycle after its accepted ren. A fifth ren sets underflow and rdata holds 0x44.
- FWFT=1: write 0xA5 into an empty FIFO. Next cycle empty=0 and rdata=0xA5 with no ren; ren pops it and empty returns to 1.
- Fill to 3 with simultaneous wen/ren for 10 cycles across pointer wrap: count stays 3 and the data order is preserved. Then assert clr: count=0, empty=1, overflow=0, underflow=0.
